// File: rtl/temp_mem_arbiter_pkg.sv
// temp_mem_arbiter_pkg: shared CiM memory-access types and sizes
package temp_mem_arbiter_pkg;
  typedef enum logic [2:0] {
    BUS_FSM       = 3'd0,
    LOGIC_FSM     = 3'd1,
    DATA_FILL_FSM = 3'd2,
    MAC           = 3'd3,
    LAYERNORM     = 3'd4,
    SOFTMAX       = 3'd5
  } mem_access_src_t;
  localparam int MEM_ACCESS_SRC_NUM = 6;
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 256;
  localparam int N_STORAGE = 16;
  localparam int N_SRC = MEM_ACCESS_SRC_NUM;
  localparam int N_T2 = N_SRC - 1;
  localparam int SRC_W = 3;
  localparam int ADDR_W = $clog2(TEMP_RES_STORAGE_SIZE_CIM);
  localparam int DATA_W = N_STORAGE;
  function automatic logic [N_SRC-1:0] src_onehot(input logic [SRC_W-1:0] s);
    return N_SRC'(1) << s;
  endfunction
endpackage

// File: rtl/temp_mem_arbiter_if.sv
// temp_mem_arbiter_if: MemAccessSignals bundle between requesters and the arbiter
interface temp_mem_arbiter_if;
  import temp_mem_arbiter_pkg::*;
  logic [N_SRC-1:0]  read_req_src;
  logic [N_SRC-1:0]  write_req_src;
  logic [ADDR_W-1:0] addr_table [N_SRC];
  logic [DATA_W-1:0] write_data [N_SRC];
  logic [N_SRC-1:0]  grant;
  logic [N_SRC-1:0]  rd_valid;
  logic [DATA_W-1:0] rd_data;
  modport master (
    output read_req_src, write_req_src, addr_table, write_data,
    input  grant, rd_valid, rd_data
  );
  modport slave (
    input  read_req_src, write_req_src, addr_table, write_data,
    output grant, rd_valid, rd_data
  );
endinterface

// File: rtl/temp_mem_arbiter_rr_arbiter_mask.sv
// rr_arbiter_mask: combinational round-robin, lowest requester at or above ptr, else lowest overall
module rr_arbiter_mask #(
  parameter int N = 5,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] hi;
  // mask off requesters below the pointer, fall back to the full vector when none remain
  always_comb begin
    hi = '0;
    gnt = '0;
    for (int i = 0; i < N; i++) hi[i] = req[i] && (PW'(i) >= ptr);
    for (int i = N - 1; i >= 0; i--) if (|hi ? hi[i] : req[i]) gnt = N'(1) << i;
  end
endmodule

// File: rtl/temp_mem_arbiter.sv
// temp_mem_arbiter: single-port temp storage arbiter, bus priority plus round-robin, tagged read return
module temp_mem_arbiter
  import temp_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  temp_mem_arbiter_if.slave req_if,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_rw_same_src,
  output logic [15:0]       conflict_cnt
);
  logic [N_SRC-1:0]  req, grant, rd_valid_q, rd_valid_d;
  logic [N_T2-1:0]   t2_gnt;
  logic [SRC_W-1:0]  ptr_q, ptr_d, sel;
  logic              any_gnt, is_wr, is_rd, multi;
  logic [MEM_LAT-1:0] pv_q, pv_d;
  logic [SRC_W-1:0]  ps_q [MEM_LAT];
  logic [SRC_W-1:0]  ps_d [MEM_LAT];
  logic              mem_en_q, mem_en_d, mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rd_hold_q, rd_hold_d, rd_data;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  assign req = rst ? '0 : (req_if.read_req_src | req_if.write_req_src);

  rr_arbiter_mask #(.N(N_T2)) u_rr (
    .req(req[N_SRC-1:1]),
    .ptr(ptr_q),
    .gnt(t2_gnt)
  );

  assign rd_data = |rd_valid_q ? mem_rdata : rd_hold_q;
  assign req_if.grant = grant;
  assign req_if.rd_valid = rd_valid_q;
  assign req_if.rd_data = rd_data;
  assign mem_en = mem_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_rw_same_src = err_q;
  assign conflict_cnt = cnt_q;

  // grant selection, command build, pointer advance, read-tag pipeline and status
  always_comb begin
    grant = req[BUS_FSM] ? N_SRC'(1) : {t2_gnt, 1'b0};
    sel = '0;
    for (int i = 0; i < N_SRC; i++) if (grant[i]) sel = SRC_W'(i);
    any_gnt = |grant;
    is_wr = |(grant & req_if.write_req_src);
    is_rd = any_gnt && !is_wr;
    multi = |(req & (req - N_SRC'(1)));
    ptr_d = (any_gnt && !req[BUS_FSM]) ? ((sel == SRC_W'(SOFTMAX)) ? '0 : sel) : ptr_q;
    mem_en_d = any_gnt;
    mem_wr_en_d = any_gnt ? is_wr : mem_wr_en_q;
    mem_addr_d = any_gnt ? req_if.addr_table[sel] : mem_addr_q;
    mem_wdata_d = any_gnt ? (is_wr ? req_if.write_data[sel] : '0) : mem_wdata_q;
    pv_d = '0;
    pv_d[0] = is_rd;
    ps_d = ps_q;
    ps_d[0] = sel;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
    end
    rd_valid_d = pv_q[MEM_LAT-1] ? src_onehot(ps_q[MEM_LAT-1]) : '0;
    rd_hold_d = rd_data;
    err_d = err_q | (|(req & req_if.read_req_src & req_if.write_req_src));
    cnt_d = (multi && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  // state registers, reset flushes in-flight reads and re-aims the pointer at LOGIC_FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      pv_q <= '0;
      ps_q <= '{default: '0};
      rd_valid_q <= '0;
      rd_hold_q <= '0;
      mem_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      pv_q <= pv_d;
      ps_q <= ps_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q <= rd_hold_d;
      mem_en_q <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_temp_mem_arbiter.sv
// tb_temp_mem_arbiter: scenario tasks with a read-return scoreboard and a behavioural SRAM
module tb_temp_mem_arbiter;
  import temp_mem_arbiter_pkg::*;
  typedef struct {
    int          src;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  temp_mem_arbiter_if bus ();
  logic              mem_en, mem_wr_en, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [15:0]       conflict_cnt;

  temp_mem_arbiter #(.MEM_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .req_if(bus.slave),
    .mem_en(mem_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err_rw_same_src(err),
    .conflict_cnt(conflict_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tptr = 0;
  logic [15:0] exp_conf = 0;
  logic exp_err = 0;
  logic [15:0] shadow [256];
  logic [15:0] sram [256];
  exp_t sb [$];
  exp_t e;

  always @(posedge clk) if (mem_en) begin
    if (mem_wr_en) sram[mem_addr] <= mem_wdata;
    else mem_rdata <= sram[mem_addr];
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_valid !== (6'd1 << e.src) || bus.rd_data !== e.data) begin
        failures++;
        $display("FAIL rd_return cyc=%0d rd_valid=%b rd_data=%h expected %b / %h", cyc, bus.rd_valid, bus.rd_data, 6'd1 << e.src, e.data);
      end
    end else begin
      checks++;
      if (bus.rd_valid !== 6'd0) begin
        failures++;
        $display("FAIL rd_idle cyc=%0d rd_valid=%b expected 000000", cyc, bus.rd_valid);
      end
    end
  end

  function automatic logic [5:0] model_gnt(input logic [5:0] r, input int p);
    if (r[0]) return 6'd1;
    for (int i = 0; i < 5; i++) if (r[1 + (p + i) % 5]) return 6'd1 << (1 + (p + i) % 5);
    return 6'd0;
  endfunction

  task automatic account(input logic [5:0] g);
    logic [5:0] r;
    r = bus.read_req_src | bus.write_req_src;
    if ($countones(r) >= 2 && exp_conf != 16'hFFFF) exp_conf++;
    if (|(bus.read_req_src & bus.write_req_src)) exp_err = 1'b1;
    for (int s = 0; s < 6; s++) if (g[s]) begin
      if (bus.write_req_src[s]) shadow[bus.addr_table[s]] = bus.write_data[s];
      else sb.push_back('{src: s, data: shadow[bus.addr_table[s]], due: cyc + 2});
      if (s != 0) tptr = (s == 5) ? 0 : s;
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    bus.read_req_src = '0;
    bus.write_req_src = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear();
    for (int s = 0; s < 6; s++) begin
      bus.addr_table[s] = '0;
      bus.write_data[s] = '0;
    end
    go();
    go();
    rst = 1'b0;
    tptr = 0;
    exp_conf = 0;
    exp_err = 0;
    #1;
    checks++; if (bus.grant !== 6'd0) begin failures++; $display("FAIL reset_grant got=%b want=0", bus.grant); end
    checks++; if (mem_en !== 1'b0 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b%b want=00", mem_en, mem_wr_en); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_cmd got=%h/%h want=0/0", mem_addr, mem_wdata); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
    checks++; if (err !== 1'b0 || conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_status got=%b/%0d want=0/0", err, conflict_cnt); end
    go();
  endtask

  task automatic test_round_robin();
    logic [5:0] order [3] = '{6'b000010, 6'b001000, 6'b100000};
    logic [5:0] pend = 6'b101010;
    bus.addr_table[1] = 8'h21;
    bus.addr_table[3] = 8'h23;
    bus.addr_table[5] = 8'h25;
    for (int i = 0; i < 3; i++) begin
      bus.read_req_src = pend;
      #1;
      checks++;
      if (bus.grant !== order[i]) begin failures++; $display("FAIL rr_grant%0d got=%b want=%b", i, bus.grant, order[i]); end
      account(order[i]);
      pend &= ~order[i];
      go();
    end
    clear();
    checks++; if (conflict_cnt !== 16'd2) begin failures++; $display("FAIL rr_conflict got=%0d want=2", conflict_cnt); end
    go(); go(); go();
  endtask

  task automatic test_bus_priority();
    bus.read_req_src = 6'b010001;
    bus.addr_table[0] = 8'h30;
    bus.addr_table[4] = 8'h34;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.grant !== 6'b000001) begin failures++; $display("FAIL bus_grant%0d got=%b want=000001", i, bus.grant); end
      account(6'b000001);
      go();
    end
    bus.read_req_src = 6'b010000;
    #1;
    checks++; if (bus.grant !== 6'b010000) begin failures++; $display("FAIL bus_layernorm got=%b want=010000", bus.grant); end
    account(6'b010000);
    go();
    bus.read_req_src = 6'b100010;
    #1;
    checks++; if (bus.grant !== 6'b100000) begin failures++; $display("FAIL bus_ptr got=%b want=100000", bus.grant); end
    account(6'b100000);
    go();
    clear();
    checks++; if (conflict_cnt !== exp_conf) begin failures++; $display("FAIL bus_conflict got=%0d want=%0d", conflict_cnt, exp_conf); end
    go(); go(); go();
  endtask

  task automatic test_single_read();
    bus.read_req_src = 6'b001000;
    bus.addr_table[3] = 8'h10;
    #1;
    checks++; if (bus.grant !== 6'b001000) begin failures++; $display("FAIL sr_grant got=%b want=001000", bus.grant); end
    account(6'b001000);
    go();
    clear();
    checks++; if (mem_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 8'h10) begin failures++; $display("FAIL sr_cmd got=%b%b/%h want=10/10", mem_en, mem_wr_en, mem_addr); end
    go(); go(); go();
  endtask

  task automatic test_write_read();
    bus.write_req_src = 6'b000100;
    bus.addr_table[2] = 8'h05;
    bus.write_data[2] = 16'hABCD;
    #1;
    checks++; if (bus.grant !== 6'b000100) begin failures++; $display("FAIL wr_grant got=%b want=000100", bus.grant); end
    account(6'b000100);
    go();
    bus.write_req_src = '0;
    bus.read_req_src = 6'b100000;
    bus.addr_table[5] = 8'h05;
    #1;
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'h05 || mem_wdata !== 16'hABCD) begin failures++; $display("FAIL wr_cmd got=%b/%h/%h want=1/05/abcd", mem_wr_en, mem_addr, mem_wdata); end
    checks++; if (bus.grant !== 6'b100000) begin failures++; $display("FAIL raw_grant got=%b want=100000", bus.grant); end
    account(6'b100000);
    go();
    clear();
    checks++; if (mem_wr_en !== 1'b0 || mem_wdata !== 16'h0) begin failures++; $display("FAIL raw_cmd got=%b/%h want=0/0000", mem_wr_en, mem_wdata); end
    go(); go(); go();
  endtask

  task automatic test_error();
    bus.read_req_src = 6'b001000;
    bus.write_req_src = 6'b001000;
    bus.addr_table[3] = 8'h07;
    bus.write_data[3] = 16'h0055;
    #1;
    checks++; if (bus.grant !== 6'b001000) begin failures++; $display("FAIL err_grant got=%b want=001000", bus.grant); end
    account(6'b001000);
    go();
    clear();
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'h07 || mem_wdata !== 16'h0055) begin failures++; $display("FAIL err_cmd got=%b/%h/%h want=1/07/0055", mem_wr_en, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
    go(); go(); go(); go();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
  endtask

  task automatic test_reset_mid_read();
    bus.read_req_src = 6'b000100;
    bus.addr_table[2] = 8'h40;
    #1;
    checks++; if (bus.grant !== 6'b000100) begin failures++; $display("FAIL mr_grant got=%b want=000100", bus.grant); end
    go();
    rst = 1'b1;
    clear();
    bus.write_req_src = 6'b000010;
    bus.addr_table[1] = 8'h41;
    bus.write_data[1] = 16'h9999;
    #1;
    checks++; if (bus.grant !== 6'd0) begin failures++; $display("FAIL mr_rst_grant got=%b want=0", bus.grant); end
    go();
    rst = 1'b0;
    clear();
    tptr = 0;
    exp_conf = 0;
    exp_err = 0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL mr_cmd got=%b/%h/%h want=0/0/0", mem_en, mem_addr, mem_wdata); end
    checks++; if (err !== 1'b0 || conflict_cnt !== 16'd0 || bus.rd_data !== '0) begin failures++; $display("FAIL mr_status got=%b/%0d/%h want=0/0/0", err, conflict_cnt, bus.rd_data); end
    bus.read_req_src = 6'b001010;
    bus.addr_table[3] = 8'h43;
    #1;
    checks++; if (bus.grant !== 6'b000010) begin failures++; $display("FAIL mr_first got=%b want=000010", bus.grant); end
    account(6'b000010);
    go();
    bus.read_req_src = 6'b001000;
    #1;
    checks++; if (bus.grant !== 6'b001000) begin failures++; $display("FAIL mr_second got=%b want=001000", bus.grant); end
    account(6'b001000);
    go();
    clear();
    checks++; if (conflict_cnt !== 16'd1) begin failures++; $display("FAIL mr_conflict got=%0d want=1", conflict_cnt); end
    go(); go(); go();
  endtask

  task automatic test_random();
    logic [5:0] pend_r = '0;
    logic [5:0] pend_w = '0;
    logic [5:0] g;
    logic pv_en = 1'b0;
    logic [7:0] pv_addr = '0;
    int waits [6] = '{default: 0};
    int kind;
    for (int c = 0; c < 150; c++) begin
      for (int s = 0; s < 6; s++) if (!(pend_r[s] | pend_w[s]) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 9);
        pend_w[s] = (kind < 4) || (kind == 9);
        pend_r[s] = (kind >= 4);
        bus.addr_table[s] = 8'($urandom_range(0, 15));
        bus.write_data[s] = 16'($urandom);
        waits[s] = 0;
      end
      bus.read_req_src = pend_r;
      bus.write_req_src = pend_w;
      #1;
      g = model_gnt(pend_r | pend_w, tptr);
      checks++;
      if (bus.grant !== g) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, bus.grant, g); end
      checks++;
      if (mem_en !== pv_en || (pv_en && mem_addr !== pv_addr)) begin failures++; $display("FAIL rand_cmd cyc=%0d got=%b/%h want=%b/%h", cyc, mem_en, mem_addr, pv_en, pv_addr); end
      if (|g[5:1]) for (int s = 1; s < 6; s++) begin
        if (g[s]) begin
          checks++;
          if (waits[s] > 4) begin failures++; $display("FAIL rand_starve src=%0d waited=%0d limit=4", s, waits[s]); end
        end else if (pend_r[s] | pend_w[s]) waits[s]++;
      end
      pv_en = |g;
      for (int s = 0; s < 6; s++) if (g[s]) pv_addr = bus.addr_table[s];
      account(g);
      pend_r &= ~g;
      pend_w &= ~g;
      go();
    end
    clear();
    go(); go(); go(); go();
    checks++; if (conflict_cnt !== exp_conf) begin failures++; $display("FAIL rand_conflict got=%0d want=%0d", conflict_cnt, exp_conf); end
    checks++; if (err !== exp_err) begin failures++; $display("FAIL rand_err got=%b want=%b", err, exp_err); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d want=0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'(i * 7 + 3);
      shadow[i] = 16'(i * 7 + 3);
    end
    sram[8'h10] = 16'h1234;
    shadow[8'h10] = 16'h1234;
    test_reset();
    test_round_robin();
    test_bus_priority();
    test_single_read();
    test_write_read();
    test_error();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
